// File: rtl/ula_seq_if.sv
// Operand/result channel of ula_seq: valid/ready operand input, valid/ready
// result output carrying the branch flags.
interface ula_seq_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             flag_lt;
    logic             flag_ltu;
    logic             illegal;

    modport master (
        output in_valid, op, s1, s2, out_ready,
        input  in_ready, out_valid, res, flag_z, flag_n, flag_c, flag_v,
               flag_lt, flag_ltu, illegal
    );

    modport slave (
        input  in_valid, op, s1, s2, out_ready,
        output in_ready, out_valid, res, flag_z, flag_n, flag_c, flag_v,
               flag_lt, flag_ltu, illegal
    );
endinterface

// File: rtl/ula_seq.sv
// Handshaked ALU with registered result/flags and an iterative shifter.
//   state | meaning
//   IDLE  | accepting operations; single-cycle ops complete here
//   SHIFT | shifting SHIFT_STEP bits per cycle until the amount is used up
//   HOLD  | shift result valid, waiting for the consumer
module ula_seq #(
    parameter int WIDTH      = 64,
    parameter int SHIFT_STEP = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    ula_seq_if.slave  bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W:0] STEP = (SHAMT_W+1)'(SHIFT_STEP);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e state, state_nx;

    logic             xfer;
    logic             is_shift;
    logic             shamt_nz;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic             add_v;
    logic             sub_v;
    logic             cmp_lt;
    logic             cmp_ltu;

    logic [WIDTH-1:0] sh_val;
    logic [SHAMT_W:0] sh_rem;
    logic [3:0]       sh_op;
    logic             sh_lt;
    logic             sh_ltu;
    logic [SHAMT_W:0] step;
    logic [WIDTH-1:0] sh_next;

    logic             ld;
    logic [WIDTH-1:0] ld_res;
    logic             ld_c;
    logic             ld_v;
    logic             ld_lt;
    logic             ld_ltu;
    logic             ld_ill;
    logic             sh_start;
    logic             sh_adv;

    assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign is_shift     = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);
    assign shamt_nz     = (bus.s2[SHAMT_W-1:0] != '0);

    // The compare flags always come from s1 - s2, so the subtractor runs for every op.
    assign add_full = {1'b0, bus.s1} + {1'b0, bus.s2};
    assign sub_full = {1'b0, bus.s1} + {1'b0, ~bus.s2} + {{WIDTH{1'b0}}, 1'b1};
    assign add_v    = (bus.s1[WIDTH-1] == bus.s2[WIDTH-1]) &&
                      (add_full[WIDTH-1] != bus.s1[WIDTH-1]);
    assign sub_v    = (bus.s1[WIDTH-1] == ~bus.s2[WIDTH-1]) &&
                      (sub_full[WIDTH-1] != bus.s1[WIDTH-1]);
    assign cmp_lt   = sub_full[WIDTH-1] ^ sub_v;
    assign cmp_ltu  = ~sub_full[WIDTH];

    assign step = (sh_rem < STEP) ? sh_rem : STEP;

    // SRA keeps the MSB in place, so the original sign keeps filling every step.
    always_comb begin
        sh_next = sh_val;
        case (sh_op)
            OP_SLL:  sh_next = sh_val << step;
            OP_SRL:  sh_next = sh_val >> step;
            OP_SRA:  sh_next = $signed(sh_val) >>> step;
            default: sh_next = sh_val;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ld       = 1'b0;
        ld_res   = '0;
        ld_c     = 1'b0;
        ld_v     = 1'b0;
        ld_lt    = 1'b0;
        ld_ltu   = 1'b0;
        ld_ill   = 1'b0;
        sh_start = 1'b0;
        sh_adv   = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    if (is_shift && shamt_nz) begin
                        sh_start = 1'b1;
                        state_nx = SHIFT;
                    end else begin
                        ld     = 1'b1;
                        ld_lt  = cmp_lt;
                        ld_ltu = cmp_ltu;
                        case (bus.op)
                            OP_ADD: begin
                                ld_res = add_full[WIDTH-1:0];
                                ld_c   = add_full[WIDTH];
                                ld_v   = add_v;
                            end
                            OP_SUB: begin
                                ld_res = sub_full[WIDTH-1:0];
                                ld_c   = sub_full[WIDTH];
                                ld_v   = sub_v;
                            end
                            OP_AND: ld_res = bus.s1 & bus.s2;
                            OP_OR:  ld_res = bus.s1 | bus.s2;
                            OP_XOR: ld_res = bus.s1 ^ bus.s2;
                            OP_SLT: begin
                                ld_res = {{(WIDTH-1){1'b0}}, cmp_lt};
                                ld_c   = sub_full[WIDTH];
                                ld_v   = sub_v;
                            end
                            OP_SLTU: begin
                                ld_res = {{(WIDTH-1){1'b0}}, cmp_ltu};
                                ld_c   = sub_full[WIDTH];
                                ld_v   = sub_v;
                            end
                            OP_SLL, OP_SRL, OP_SRA: ld_res = bus.s1;
                            default: begin
                                ld_res = '0;
                                ld_lt  = 1'b0;
                                ld_ltu = 1'b0;
                                ld_ill = 1'b1;
                            end
                        endcase
                    end
                end
            end
            SHIFT: begin
                sh_adv = 1'b1;
                if (sh_rem == step) begin
                    ld       = 1'b1;
                    ld_res   = sh_next;
                    ld_lt    = sh_lt;
                    ld_ltu   = sh_ltu;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_valid && bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.res       <= '0;
            bus.flag_z    <= 1'b0;
            bus.flag_n    <= 1'b0;
            bus.flag_c    <= 1'b0;
            bus.flag_v    <= 1'b0;
            bus.flag_lt   <= 1'b0;
            bus.flag_ltu  <= 1'b0;
            bus.illegal   <= 1'b0;
            sh_val        <= '0;
            sh_rem        <= '0;
            sh_op         <= '0;
            sh_lt         <= 1'b0;
            sh_ltu        <= 1'b0;
        end else begin
            if (ld) begin
                bus.out_valid <= 1'b1;
                bus.res       <= ld_res;
                bus.flag_z    <= (ld_res == '0);
                bus.flag_n    <= ld_res[WIDTH-1];
                bus.flag_c    <= ld_c;
                bus.flag_v    <= ld_v;
                bus.flag_lt   <= ld_lt;
                bus.flag_ltu  <= ld_ltu;
                bus.illegal   <= ld_ill;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            if (sh_start) begin
                sh_val <= bus.s1;
                sh_rem <= {1'b0, bus.s2[SHAMT_W-1:0]};
                sh_op  <= bus.op;
                sh_lt  <= cmp_lt;
                sh_ltu <= cmp_ltu;
            end else if (sh_adv) begin
                sh_val <= sh_next;
                sh_rem <= sh_rem - step;
            end
        end
    end
endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq: arithmetic/compare flags, iterative shifts,
// output backpressure, asynchronous reset mid-shift and illegal opcodes.
module tb_ula_seq;
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, XOR_ = 4'd4;
    localparam logic [3:0] SLT = 4'd5, SLTU = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9;
    localparam logic [63:0] MSB = 64'h8000_0000_0000_0000;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   lat;
    int   low;
    int   seen;

    logic [63:0] bp_a [4];
    logic [63:0] bp_b [4];
    logic [63:0] bp_r [4];
    logic        bp_z [4];
    logic        bp_n [4];
    logic        bp_c [4];
    logic        bp_v [4];
    logic        bp_lt [4];
    logic        bp_ltu [4];

    ula_seq_if #(.WIDTH(64)) bus ();

    ula_seq #(.WIDTH(64), .SHIFT_STEP(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string t, input logic [63:0] r, input logic z, input logic n,
                           input logic c, input logic v, input logic lt, input logic ltu,
                           input logic ill);
        chk({t, ".res"}, bus.res, r);
        chk({t, ".z"}, {63'd0, bus.flag_z}, {63'd0, z});
        chk({t, ".n"}, {63'd0, bus.flag_n}, {63'd0, n});
        chk({t, ".c"}, {63'd0, bus.flag_c}, {63'd0, c});
        chk({t, ".v"}, {63'd0, bus.flag_v}, {63'd0, v});
        chk({t, ".lt"}, {63'd0, bus.flag_lt}, {63'd0, lt});
        chk({t, ".ltu"}, {63'd0, bus.flag_ltu}, {63'd0, ltu});
        chk({t, ".ill"}, {63'd0, bus.illegal}, {63'd0, ill});
    endtask

    // Presents one op for a single cycle; returns at the negedge after the transfer edge.
    task automatic do_op(input string t, input logic [3:0] o, input logic [63:0] a,
                         input logic [63:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.s1       = a;
        bus.s2       = b;
        #1;
        chk({t, ".in_ready"}, {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Cycle k=1 is the cycle right after the transfer edge.
    task automatic wait_out(output int l, output int lo);
        l  = 0;
        lo = 0;
        for (int k = 1; k <= 20; k++) begin
            if (bus.out_valid && l == 0) l = k;
            if (bus.in_ready) break;
            lo++;
            @(negedge clk);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 4'd0;
        bus.s1        = '0;
        bus.s2        = '0;
        bus.out_ready = 1'b1;

        @(negedge clk);
        @(negedge clk);
        chk("rst.out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst.in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk_out("rst", 64'd0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        do_op("sub1", SUB, 64'd1, -64'd45);
        chk("sub1.out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk_out("sub1", 64'd46, 0, 0, 0, 0, 0, 1, 0);

        do_op("sub2", SUB, MSB, MSB - 64'd1);
        chk("sub2.out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk_out("sub2", 64'd1, 0, 0, 1, 1, 1, 0, 0);

        do_op("sub3", SUB, -64'd2, -64'd2);
        chk_out("sub3", 64'd0, 1, 0, 1, 0, 0, 0, 0);

        do_op("sltu1", SLTU, 64'd12873481, '1);
        chk_out("sltu1", 64'd1, 0, 0, 0, 0, 0, 1, 0);

        do_op("sltu2", SLTU, '1, 64'd12873481);
        chk_out("sltu2", 64'd0, 1, 0, 1, 0, 1, 0, 0);

        do_op("slt", SLT, -64'd5, 64'd3);
        chk_out("slt", 64'd1, 0, 0, 1, 0, 1, 0, 0);

        do_op("and", AND_, 64'hF0F0, 64'hFF00);
        chk_out("and", 64'hF000, 0, 0, 0, 0, 1, 1, 0);

        do_op("xor", XOR_, 64'hFF00, 64'h0FF0);
        chk_out("xor", 64'hF0F0, 0, 0, 0, 0, 0, 0, 0);

        do_op("sra63", SRA, MSB, 64'd63);
        wait_out(lat, low);
        chk("sra63.latency", 64'(lat), 64'd9);
        chk("sra63.in_ready_low", 64'(low), 64'd9);
        chk_out("sra63", '1, 0, 1, 0, 0, 1, 0, 0);

        do_op("sra0", SRA, MSB, 64'd0);
        chk("sra0.out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk_out("sra0", MSB, 0, 1, 0, 0, 1, 0, 0);

        do_op("srl63", SRL, MSB, 64'd63);
        wait_out(lat, low);
        chk("srl63.latency", 64'(lat), 64'd9);
        chk_out("srl63", 64'd1, 0, 0, 0, 0, 1, 0, 0);

        do_op("sll13", SLL, 64'd1, 64'd13);
        wait_out(lat, low);
        chk("sll13.latency", 64'(lat), 64'd3);
        chk_out("sll13", 64'h2000, 0, 0, 0, 0, 1, 1, 0);

        // Backpressure: result held, new operation waits, then 4 ADDs stream.
        bp_a = '{64'd1, 64'd100, '1, MSB - 64'd1};
        bp_b = '{64'd2, 64'd200, 64'd1, 64'd1};
        bp_r = '{64'd3, 64'd300, 64'd0, MSB};
        bp_z = '{0, 0, 1, 0};
        bp_n = '{0, 0, 0, 1};
        bp_c = '{0, 0, 1, 0};
        bp_v = '{0, 0, 0, 1};
        bp_lt = '{1, 1, 1, 0};
        bp_ltu = '{1, 1, 0, 0};

        bus.out_ready = 1'b0;
        do_op("bp", ADD, 64'd30, 64'd29);
        chk_out("bp", 64'd59, 0, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b1;
        bus.op       = ADD;
        bus.s1       = bp_a[0];
        bus.s2       = bp_b[0];
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp.stall.out_valid", {63'd0, bus.out_valid}, 64'd1);
            chk("bp.stall.res", bus.res, 64'd59);
            chk("bp.stall.in_ready", {63'd0, bus.in_ready}, 64'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", {63'd0, bus.in_ready}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp.stream.out_valid", {63'd0, bus.out_valid}, 64'd1);
            chk_out("bp.stream", bp_r[i], bp_z[i], bp_n[i], bp_c[i], bp_v[i],
                    bp_lt[i], bp_ltu[i], 0);
            if (i < 3) begin
                bus.s1 = bp_a[i+1];
                bus.s2 = bp_b[i+1];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("bp.drain.out_valid", {63'd0, bus.out_valid}, 64'd0);

        // Asynchronous reset in the middle of a shift.
        do_op("rstsh", SLL, 64'd5, 64'd40);
        @(negedge clk);
        chk("rstsh.busy", {63'd0, bus.in_ready}, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstsh.out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rstsh.res", bus.res, 64'd0);
        chk("rstsh.in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("rstsh.no_replay", 64'(seen), 64'd0);

        do_op("illegal", 4'd15, 64'd1, 64'd5);
        chk("illegal.out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk_out("illegal", 64'd0, 1, 0, 0, 0, 0, 0, 1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
